wd_config_regfile: RTL and testbench

- Multi-channel configuration register file for the watchdog timers.
- Each channel holds FWLEN, SWLEN, SERVICE and RST_LMT, the first/second window lengths, service/status bits and reset limit.
- Window and reset-limit registers are protected by a two-key unlock state machine with an auto-relock timeout; SERVICE bits are sticky OR-set and always writable.
- Sits between the host bus and NUM_CH watchdog channel cores; adds registered readback and a write-error flag.

---
 rtl/wd_config_regfile_if.sv | 24 ++
 rtl/wd_config_regfile.sv | 167 ++++++++++++++++
 tb/tb_wd_config_regfile.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/wd_config_regfile_if.sv
// Host-side bus for the watchdog configuration register file: write, key and readback signals.
interface wd_config_regfile_if #(
    parameter int unsigned CH_AW = 1,
    parameter int unsigned DW    = 8
);
    logic              WREN;
    logic [CH_AW+1:0]  ABUS;
    logic [DW-1:0]     DBUS;
    logic              KEY_WREN;
    logic              RDEN;
    logic [CH_AW+1:0]  RADDR;
    logic [DW-1:0]     RDATA;
    logic              RVALID;

    modport master (
        output WREN, ABUS, DBUS, KEY_WREN, RDEN, RADDR,
        input  RDATA, RVALID
    );

    modport slave (
        input  WREN, ABUS, DBUS, KEY_WREN, RDEN, RADDR,
        output RDATA, RVALID
    );
endinterface

// File: rtl/wd_config_regfile.sv
// Per-channel watchdog configuration registers behind a two-key unlock FSM with auto-relock.
// Optional registered readback path is built only when CFG_READBACK_EN is defined.
module wd_config_regfile #(
    parameter int unsigned CH_AW     = 1,
    parameter int unsigned DW        = 8,
    parameter int unsigned UNLOCK_TO = 16
) (
    input  logic                          CLK,
    input  logic                          RST,
    wd_config_regfile_if.slave            bus,
    output logic [(2**CH_AW)*DW-1:0]      FWLEN,
    output logic [(2**CH_AW)*DW-1:0]      SWLEN,
    output logic [(2**CH_AW)*DW-1:0]      RST_LMT,
    output logic [(2**CH_AW)-1:0]         INIT,
    output logic [(2**CH_AW)-1:0]         WDSRVC,
    output logic [(2**CH_AW)*3-1:0]       FLSTAT,
    output logic                          LOCKED,
    output logic                          WERR
);
    localparam int unsigned NUM_CH = 2**CH_AW;
    localparam int unsigned CW     = (UNLOCK_TO > 1) ? $clog2(UNLOCK_TO) : 1;

    localparam logic [1:0] REG_FWLEN   = 2'b00;
    localparam logic [1:0] REG_SWLEN   = 2'b01;
    localparam logic [1:0] REG_SERVICE = 2'b10;
    localparam logic [1:0] REG_RSTLMT  = 2'b11;

    localparam logic [7:0] KEY_ARM    = 8'hA5;
    localparam logic [7:0] KEY_UNLOCK = 8'h5A;

    typedef enum logic [1:0] {
        ST_LOCKED,
        ST_ARMED,
        ST_UNLOCKED
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            locked_q;
    logic            werr_q;
    logic [DW-1:0]   fwlen_q  [NUM_CH];
    logic [DW-1:0]   swlen_q  [NUM_CH];
    logic [DW-1:0]   rstlmt_q [NUM_CH];
    logic [DW-1:0]   svc_q    [NUM_CH];

    logic [CH_AW-1:0] wch;
    logic [1:0]       wreg;
    logic [7:0]       key;

    assign wch  = bus.ABUS[CH_AW+1:2];
    assign wreg = bus.ABUS[1:0];
    assign key  = bus.DBUS[7:0];

    // Register writes are judged against the pre-edge state; the lock FSM advances in the same edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_LOCKED;
            cnt      <= '0;
            locked_q <= 1'b1;
            werr_q   <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                fwlen_q[c]  <= '0;
                swlen_q[c]  <= '0;
                rstlmt_q[c] <= '0;
                svc_q[c]    <= '0;
            end
        end else begin
            if (bus.WREN) begin
                if (wreg == REG_SERVICE) begin
                    svc_q[wch] <= svc_q[wch] | bus.DBUS;
                end else if (state == ST_UNLOCKED) begin
                    case (wreg)
                        REG_FWLEN:  fwlen_q[wch]  <= bus.DBUS;
                        REG_SWLEN:  swlen_q[wch]  <= bus.DBUS;
                        REG_RSTLMT: rstlmt_q[wch] <= bus.DBUS;
                        default:    ;
                    endcase
                end else begin
                    werr_q <= 1'b1;
                end
            end

            case (state)
                ST_LOCKED: begin
                    if (bus.KEY_WREN && key == KEY_ARM) begin
                        state <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (bus.KEY_WREN) begin
                        if (key == KEY_UNLOCK) begin
                            state    <= ST_UNLOCKED;
                            cnt      <= CW'(UNLOCK_TO - 1);
                            locked_q <= 1'b0;
                        end else begin
                            state <= ST_LOCKED;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (bus.KEY_WREN || cnt == '0) begin
                        state    <= ST_LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: begin
                    state    <= ST_LOCKED;
                    locked_q <= 1'b1;
                end
            endcase
        end
    end

    assign LOCKED = locked_q;
    assign WERR   = werr_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign FWLEN[c*DW +: DW]   = fwlen_q[c];
        assign SWLEN[c*DW +: DW]   = swlen_q[c];
        assign RST_LMT[c*DW +: DW] = rstlmt_q[c];
        assign INIT[c]             = svc_q[c][4];
        assign WDSRVC[c]           = svc_q[c][3];
        assign FLSTAT[c*3 +: 3]    = svc_q[c][2:0];
`ifndef CFG_READBACK_EN
        // Upper SERVICE bits are only observable through readback.
        logic unused_svc_hi;
        assign unused_svc_hi = ^svc_q[c][DW-1:5];
`endif
    end

`ifdef CFG_READBACK_EN
    logic [DW-1:0]    rdata_q;
    logic             rvalid_q;
    logic [CH_AW-1:0] rch;

    assign rch = bus.RADDR[CH_AW+1:2];

    // Read mux samples pre-write register values, so a same-cycle write is not visible yet.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rvalid_q <= bus.RDEN;
            if (bus.RDEN) begin
                case (bus.RADDR[1:0])
                    REG_FWLEN:   rdata_q <= fwlen_q[rch];
                    REG_SWLEN:   rdata_q <= swlen_q[rch];
                    REG_SERVICE: rdata_q <= svc_q[rch];
                    default:     rdata_q <= rstlmt_q[rch];
                endcase
            end
        end
    end

    assign bus.RDATA  = rdata_q;
    assign bus.RVALID = rvalid_q;
`else
    logic unused_rd;
    assign unused_rd  = ^{bus.RDEN, bus.RADDR};
    assign bus.RDATA  = '0;
    assign bus.RVALID = 1'b0;
`endif

endmodule

// File: tb/tb_wd_config_regfile.sv
// Directed bench for wd_config_regfile: vector table plus hand sequences for timeout, readback and reset.
module tb_wd_config_regfile;
    localparam int unsigned CH_AW = 1;
    localparam int unsigned DW    = 8;
`ifdef CFG_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] FWLEN, SWLEN, RST_LMT;
    logic [1:0]  INIT, WDSRVC;
    logic [5:0]  FLSTAT;
    logic        LOCKED, WERR;

    int checks = 0;
    int errors = 0;

    wd_config_regfile_if #(.CH_AW(CH_AW), .DW(DW)) bus ();

    wd_config_regfile #(.CH_AW(CH_AW), .DW(DW), .UNLOCK_TO(16)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus),
        .FWLEN   (FWLEN),
        .SWLEN   (SWLEN),
        .RST_LMT (RST_LMT),
        .INIT    (INIT),
        .WDSRVC  (WDSRVC),
        .FLSTAT  (FLSTAT),
        .LOCKED  (LOCKED),
        .WERR    (WERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wren;
        logic [2:0]  abus;
        logic [7:0]  dbus;
        logic        key;
        logic        e_locked;
        logic        e_werr;
        logic [15:0] e_fw;
        logic [15:0] e_sw;
        logic [15:0] e_rl;
        logic [1:0]  e_init;
        logic [1:0]  e_wd;
        logic [5:0]  e_fl;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Drive inputs at negedge, let one posedge sample them, return 1ns later for checking.
    task automatic cyc(input logic rst, input logic wren, input logic [2:0] abus,
                       input logic [7:0] dbus, input logic key,
                       input logic rden, input logic [2:0] raddr);
        @(negedge CLK);
        RST          = rst;
        bus.WREN     = wren;
        bus.ABUS     = abus;
        bus.DBUS     = dbus;
        bus.KEY_WREN = key;
        bus.RDEN     = rden;
        bus.RADDR    = raddr;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic key_wr(input logic [7:0] k);
        cyc(1'b0, 1'b0, 3'd0, k, 1'b1, 1'b0, 3'd0);
    endtask

    task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
        cyc(1'b0, 1'b1, a, d, 1'b0, 1'b0, 3'd0);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_fwlen"},  32'(FWLEN),   32'h0);
        chk({tag, "_swlen"},  32'(SWLEN),   32'h0);
        chk({tag, "_rstlmt"}, 32'(RST_LMT), 32'h0);
        chk({tag, "_svc"},    32'({INIT, WDSRVC, FLSTAT}), 32'h0);
        chk({tag, "_locked"}, 32'(LOCKED),  32'h1);
        chk({tag, "_werr"},   32'(WERR),    32'h0);
        chk({tag, "_rdata"},  32'(bus.RDATA),  32'h0);
        chk({tag, "_rvalid"}, 32'(bus.RVALID), 32'h0);
    endtask

    function automatic vec_t mk(input logic wren, input logic [2:0] abus, input logic [7:0] dbus,
                                input logic key, input logic lk, input logic we,
                                input logic [15:0] fw, input logic [15:0] sw, input logic [15:0] rl,
                                input logic [1:0] ini, input logic [1:0] wd, input logic [5:0] fl);
        vec_t v;
        v.wren = wren; v.abus = abus; v.dbus = dbus; v.key = key;
        v.e_locked = lk; v.e_werr = we; v.e_fw = fw; v.e_sw = sw; v.e_rl = rl;
        v.e_init = ini; v.e_wd = wd; v.e_fl = fl;
        return v;
    endfunction

    initial begin
        RST = 1'b1;
        bus.WREN = 1'b0; bus.ABUS = '0; bus.DBUS = '0;
        bus.KEY_WREN = 1'b0; bus.RDEN = 1'b0; bus.RADDR = '0;

        //            wren abus    dbus  key  lk we  fw       sw       rl       ini    wd     fl
        vt[0]  = mk(1, 3'b000, 8'h20, 0,  1, 1, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 6'o00);
        vt[1]  = mk(0, 3'b000, 8'hA5, 1,  1, 1, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 6'o00);
        vt[2]  = mk(0, 3'b000, 8'h5A, 1,  0, 1, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00, 6'o00);
        vt[3]  = mk(1, 3'b101, 8'h33, 0,  0, 1, 16'h0000, 16'h3300, 16'h0000, 2'b00, 2'b00, 6'o00);
        vt[4]  = mk(1, 3'b000, 8'h20, 0,  0, 1, 16'h0020, 16'h3300, 16'h0000, 2'b00, 2'b00, 6'o00);
        vt[5]  = mk(1, 3'b111, 8'h7F, 0,  0, 1, 16'h0020, 16'h3300, 16'h7F00, 2'b00, 2'b00, 6'o00);
        vt[6]  = mk(1, 3'b010, 8'h01, 0,  0, 1, 16'h0020, 16'h3300, 16'h7F00, 2'b00, 2'b00, 6'o01);
        vt[7]  = mk(1, 3'b010, 8'h08, 0,  0, 1, 16'h0020, 16'h3300, 16'h7F00, 2'b00, 2'b01, 6'o01);
        vt[8]  = mk(0, 3'b000, 8'h00, 1,  1, 1, 16'h0020, 16'h3300, 16'h7F00, 2'b00, 2'b01, 6'o01);
        vt[9]  = mk(1, 3'b001, 8'h44, 0,  1, 1, 16'h0020, 16'h3300, 16'h7F00, 2'b00, 2'b01, 6'o01);
        vt[10] = mk(0, 3'b000, 8'hA5, 1,  1, 1, 16'h0020, 16'h3300, 16'h7F00, 2'b00, 2'b01, 6'o01);
        vt[11] = mk(0, 3'b000, 8'h11, 1,  1, 1, 16'h0020, 16'h3300, 16'h7F00, 2'b00, 2'b01, 6'o01);
        vt[12] = mk(0, 3'b000, 8'h5A, 1,  1, 1, 16'h0020, 16'h3300, 16'h7F00, 2'b00, 2'b01, 6'o01);
        vt[13] = mk(1, 3'b100, 8'h99, 0,  1, 1, 16'h0020, 16'h3300, 16'h7F00, 2'b00, 2'b01, 6'o01);
        vt[14] = mk(1, 3'b110, 8'h10, 0,  1, 1, 16'h0020, 16'h3300, 16'h7F00, 2'b10, 2'b01, 6'o01);

        do_reset();
        do_reset();
        chk_all_zero("reset");

        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, vt[i].wren, vt[i].abus, vt[i].dbus, vt[i].key, 1'b0, 3'd0);
            chk($sformatf("vec%0d_locked", i), 32'(LOCKED),  32'(vt[i].e_locked));
            chk($sformatf("vec%0d_werr", i),   32'(WERR),    32'(vt[i].e_werr));
            chk($sformatf("vec%0d_fwlen", i),  32'(FWLEN),   32'(vt[i].e_fw));
            chk($sformatf("vec%0d_swlen", i),  32'(SWLEN),   32'(vt[i].e_sw));
            chk($sformatf("vec%0d_rstlmt", i), 32'(RST_LMT), 32'(vt[i].e_rl));
            chk($sformatf("vec%0d_svc", i),    32'({INIT, WDSRVC, FLSTAT}),
                32'({vt[i].e_init, vt[i].e_wd, vt[i].e_fl}));
        end

        // SERVICE is writable while locked and never raises WERR.
        do_reset();
        reg_wr(3'b010, 8'h01);
        reg_wr(3'b010, 8'h08);
        chk("svc_locked_flstat", 32'(FLSTAT[2:0]), 32'h1);
        chk("svc_locked_wdsrvc", 32'(WDSRVC[0]),   32'h1);
        chk("svc_locked_werr",   32'(WERR),        32'h0);
        chk("svc_locked_locked", 32'(LOCKED),      32'h1);

        // Auto-relock exactly UNLOCK_TO cycles after the unlock key edge.
        do_reset();
        key_wr(8'hA5);
        key_wr(8'h5A);
        for (int k = 1; k <= 15; k++) begin
            idle();
            chk($sformatf("timeout_open_%0d", k), 32'(LOCKED), 32'h0);
        end
        reg_wr(3'b100, 8'h66);
        chk("timeout_last_write", 32'(FWLEN[15:8]), 32'h66);
        chk("timeout_relocked",   32'(LOCKED),      32'h1);
        chk("timeout_werr_clear", 32'(WERR),        32'h0);
        reg_wr(3'b100, 8'h77);
        chk("timeout_reject_fw",  32'(FWLEN[15:8]), 32'h66);
        chk("timeout_reject_err", 32'(WERR),        32'h1);

        // ARMED holds through idle cycles.
        do_reset();
        key_wr(8'hA5);
        for (int k = 0; k < 5; k++) idle();
        chk("armed_still_locked", 32'(LOCKED), 32'h1);
        key_wr(8'h5A);
        chk("armed_then_unlock", 32'(LOCKED), 32'h0);

        // Readback with a same-cycle write to the same register.
        reg_wr(3'b111, 8'h7F);
        chk("rb_setup", 32'(RST_LMT[15:8]), 32'h7F);
        cyc(1'b0, 1'b1, 3'b111, 8'h05, 1'b0, 1'b1, 3'b111);
        chk("rb_write_applied", 32'(RST_LMT[15:8]), 32'h05);
        chk("rb_rdata_prewrite", 32'(bus.RDATA),  RB ? 32'h7F : 32'h0);
        chk("rb_rvalid_pulse",   32'(bus.RVALID), RB ? 32'h1 : 32'h0);
        idle();
        chk("rb_rvalid_low",  32'(bus.RVALID), 32'h0);
        chk("rb_rdata_hold",  32'(bus.RDATA),  RB ? 32'h7F : 32'h0);
        cyc(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1, 3'b111);
        chk("rb_rdata_new",   32'(bus.RDATA),  RB ? 32'h05 : 32'h0);
        chk("rb_rvalid_new",  32'(bus.RVALID), RB ? 32'h1 : 32'h0);
        chk("rst_pre_unlocked", 32'(LOCKED), 32'h0);

        // Reset overrides an unlocked state and a pending read.
        cyc(1'b1, 1'b1, 3'b000, 8'hFF, 1'b0, 1'b1, 3'b111);
        chk_all_zero("rst_mid");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
